issue_unit: RTL

//  Issue scheduler between the four dispatch queues (int, lw/sw, mult, div) and their execution units.
//  - Each cycle, grants at most one issue per unit.
//  - Guarantees that no two results ever target the same CDB cycle, using a CDB-slot reservation shift register.
//  - Serialises the non-pipelined divider; round-robins int vs lw/sw, which share CDB latency 1.
//  - Drives the CDB-owner select that the CDB mux consumes.

---
 rtl/issue_unit_pkg.sv | 11 +
 rtl/issue_unit_if.sv | 17 +
 rtl/issue_unit_cdb_slot_sr.sv | 46 ++++
 rtl/issue_unit.sv | 59 +++++
 4 files changed

// File: rtl/issue_unit_pkg.sv
// issue_unit_pkg: shared unit ids and default latencies for the issue scheduler.
package issue_unit_pkg;
    typedef enum logic [1:0] {
        UNIT_INT  = 2'd0,
        UNIT_LSW  = 2'd1,
        UNIT_MULT = 2'd2,
        UNIT_DIV  = 2'd3
    } unit_id_t;
    localparam int MULT_LAT_DEF = 4;
    localparam int DIV_LAT_DEF  = 8;
endpackage

// File: rtl/issue_unit_if.sv
// issue_unit_if: dispatch-queue ready/grant handshake plus CDB owner select.
interface issue_unit_if;
    import issue_unit_pkg::*;
    logic     int_ready, lsw_ready, mult_ready, div_ready;
    logic     issue_int, issue_lsw, issue_mult, issue_div;
    unit_id_t cdb_unit;
    logic     cdb_unit_valid;
    logic     div_busy;
    modport master (
        input  int_ready, lsw_ready, mult_ready, div_ready,
        output issue_int, issue_lsw, issue_mult, issue_div, cdb_unit, cdb_unit_valid, div_busy
    );
    modport slave (
        output int_ready, lsw_ready, mult_ready, div_ready,
        input  issue_int, issue_lsw, issue_mult, issue_div, cdb_unit, cdb_unit_valid, div_busy
    );
endinterface

// File: rtl/issue_unit_cdb_slot_sr.sv
// cdb_slot_sr: CDB reservation shift register; slot k holds the result due k cycles ahead.
module cdb_slot_sr
    import issue_unit_pkg::*;
#(
    parameter int DEPTH = 9,
    parameter int IW    = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [2:0]     wr_en,
    input  logic [IW-1:0]  wr_idx [3],
    input  unit_id_t       wr_unit [3],
    output logic [2:0]     wr_free,
    output logic           v0,
    output unit_id_t       u0
);
    logic [DEPTH-1:0] slot_v;
    unit_id_t         slot_u [DEPTH];
    // A write to index i after the shift lands on what is slot i+1 now.
    always_comb begin
        for (int p = 0; p < 3; p++)
            wr_free[p] = !slot_v[wr_idx[p] + 1'b1];
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_v <= '0;
            for (int k = 0; k < DEPTH; k++)
                slot_u[k] <= UNIT_INT;
        end else begin
            slot_v <= slot_v >> 1;
            for (int k = 0; k < DEPTH - 1; k++)
                slot_u[k] <= slot_u[k+1];
            slot_u[DEPTH-1] <= UNIT_INT;
            for (int p = 0; p < 3; p++)
                if (wr_en[p]) begin
                    slot_v[wr_idx[p]] <= 1'b1;
                    slot_u[wr_idx[p]] <= wr_unit[p];
                end
        end
    end
    assign v0 = slot_v[0];
    assign u0 = slot_u[0];
    for (genvar p = 0; p < 3; p++) begin : g_chk
        a_no_overwrite: assert property (@(posedge clk) disable iff (rst) wr_en[p] |-> wr_free[p]);
    end
endmodule

// File: rtl/issue_unit.sv
// issue_unit: per-unit issue grants with CDB slot reservation, divider serialisation
// and int/lsw round-robin.
module issue_unit
    import issue_unit_pkg::*;
#(
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int DIV_LAT  = DIV_LAT_DEF
) (
    input logic          clk,
    input logic          rst,
    issue_unit_if.master io
);
    localparam int IW = $clog2(DIV_LAT + 1);
    if (!(MULT_LAT >= 2 && MULT_LAT < DIV_LAT && DIV_LAT <= 31)) begin : g_bad_lat
        $error("issue_unit: need 2 <= MULT_LAT < DIV_LAT <= 31");
    end
    logic          lru;
    logic [4:0]    div_cnt;
    logic          int_ok, lsw_ok;
    logic [2:0]    wr_en, wr_free;
    logic [IW-1:0] wr_idx [3];
    unit_id_t      wr_unit [3];
    // Port 0: int/lsw (L=1), port 1: mult, port 2: div.
    assign wr_idx[0]  = '0;
    assign wr_idx[1]  = IW'(MULT_LAT - 1);
    assign wr_idx[2]  = IW'(DIV_LAT - 1);
    assign wr_unit[0] = io.issue_lsw ? UNIT_LSW : UNIT_INT;
    assign wr_unit[1] = UNIT_MULT;
    assign wr_unit[2] = UNIT_DIV;
    assign io.div_busy = div_cnt != 5'd0;
    always_comb begin
        int_ok        = io.int_ready & wr_free[0];
        lsw_ok        = io.lsw_ready & wr_free[0];
        io.issue_int  = int_ok & (!lsw_ok | !lru);
        io.issue_lsw  = lsw_ok & (!int_ok | lru);
        io.issue_mult = io.mult_ready & wr_free[1];
        io.issue_div  = io.div_ready & (div_cnt == 5'd0) & wr_free[2];
        wr_en         = {io.issue_div, io.issue_mult, io.issue_int | io.issue_lsw};
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lru     <= 1'b0;
            div_cnt <= '0;
        end else begin
            lru     <= io.issue_int ? 1'b1 : io.issue_lsw ? 1'b0 : lru;
            div_cnt <= io.issue_div ? 5'(DIV_LAT - 1) : div_cnt - 5'(div_cnt != 5'd0);
        end
    end
    cdb_slot_sr #(.DEPTH(DIV_LAT + 1)) u_sr (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_idx  (wr_idx),
        .wr_unit (wr_unit),
        .wr_free (wr_free),
        .v0      (io.cdb_unit_valid),
        .u0      (io.cdb_unit)
    );
endmodule
